// File: rtl/sfifo_wr_arb.sv
// Round-robin write arbiter in front of a sync FIFO write port.
// Tracks FIFO occupancy locally as write credits so it never depends on the
// FIFO's registered full flag. Grants bursts of up to MAX_BURST beats per owner.
module sfifo_wr_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_winc,
    output logic [WIDTH-1:0]       fifo_wdata,
    input  logic                   fifo_pop,
    output logic [IDW-1:0]         grant_id,
    output logic [LW-1:0]          level,
    output logic                   pop_err
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [LW-1:0]    level_q, level_d;
    logic             winc_q;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             pop_err_q;

    logic             credit_ok;
    logic             found;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   sel;
    logic [N_REQ-1:0] ready_raw;
    logic             accept;
    logic             pop_eff;

    // Index after p, wrapping at N_REQ (handles non-power-of-2 counts).
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] p);
        if (32'(p) >= N_REQ - 1) return '0;
        return p + 1'b1;
    endfunction

    assign credit_ok = (32'(level_q) < DEPTH);

    // Find first valid requester starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            int unsigned    idx_int;
            logic [IDW-1:0] idx;
            idx_int = 32'(rr_ptr_q) + i;
            if (idx_int >= N_REQ) idx_int = idx_int - N_REQ;
            idx = idx_int[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant decision, burst tracking and priority rotation.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_id_d = grant_id_q;
        ready_raw  = '0;
        sel        = grant_id_q;
        case (state_q)
            StIdle: begin
                if (credit_ok && found) begin
                    ready_raw[winner] = 1'b1;
                    sel               = winner;
                    grant_id_d        = winner;
                    beat_cnt_d        = CW'(1);
                    if (MAX_BURST > 1) state_d = StBurst;
                    else               rr_ptr_d = next_idx(winner);
                end
            end
            StBurst: begin
                if (!req_valid[grant_id_q]) begin
                    // Owner went idle: give up the grant with one bubble cycle.
                    state_d  = StIdle;
                    rr_ptr_d = next_idx(grant_id_q);
                end else if (credit_ok) begin
                    ready_raw[grant_id_q] = 1'b1;
                    beat_cnt_d            = beat_cnt_q + 1'b1;
                    if (32'(beat_cnt_q) + 1 == MAX_BURST) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_idx(grant_id_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready is forced low while reset is held so no beat can be taken.
    assign req_ready = ready_raw & {N_REQ{rst_n}};
    assign accept    = |(req_valid & req_ready);
    assign pop_eff   = fifo_pop && (level_q != '0);
    assign wdata_d   = accept ? req_data[sel*WIDTH +: WIDTH] : wdata_q;
    assign level_d   = level_q + LW'(accept) - LW'(pop_eff);

    // Arbiter state, credit counter and registered FIFO write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            grant_id_q <= '0;
            level_q    <= '0;
            winc_q     <= 1'b0;
            wdata_q    <= '0;
            pop_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_id_q <= grant_id_d;
            level_q    <= level_d;
            winc_q     <= accept;
            wdata_q    <= wdata_d;
            if (fifo_pop && (level_q == '0)) pop_err_q <= 1'b1;
        end
    end

    assign fifo_winc  = winc_q;
    assign fifo_wdata = wdata_q;
    assign grant_id   = grant_id_q;
    assign level      = level_q;
    assign pop_err    = pop_err_q;

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Directed bench for sfifo_wr_arb with default parameters (4 req, 8b, depth 16, burst 4).
module tb_sfifo_wr_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_winc;
    logic [7:0]  fifo_wdata;
    logic        fifo_pop;
    logic [1:0]  grant_id;
    logic [4:0]  level;
    logic        pop_err;

    int total = 0;
    int bad   = 0;

    sfifo_wr_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .fifo_pop   (fifo_pop),
        .grant_id   (grant_id),
        .level      (level),
        .pop_err    (pop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] v);
        req_data[idx*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_pop  = 1'b0;
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_winc", 32'(fifo_winc), 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_wdata", 32'(fifo_wdata), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_pop_err", 32'(pop_err), 0);
        chk("rst_ready", 32'(req_ready), 0);

        // 1: single requester streams 0x10..0x17 as two bursts of 4
        req_valid = 4'b0001;
        set_data(0, 8'h10);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t1_ready", 32'(req_ready), 32'h1);
            tick();
            chk("t1_winc", 32'(fifo_winc), 1);
            chk("t1_wdata", 32'(fifo_wdata), 32'h10 + 32'(k));
            if (k == 7) req_valid = '0;
            else        set_data(0, 8'(8'h11 + k));
        end
        #1;
        chk("t1_ready_idle", 32'(req_ready), 0);
        tick();
        chk("t1_winc_off", 32'(fifo_winc), 0);
        chk("t1_level", 32'(level), 8);
        chk("t1_grant", 32'(grant_id), 0);

        // 2: all valid, no pops: bursts 0,1,2,3 then credits exhausted
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h33221100;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("t2_ready", 32'(req_ready), 32'(1) << b);
                tick();
                chk("t2_wdata", 32'(fifo_wdata), 32'h11 * 32'(b));
                if (k == 0) chk("t2_grant", 32'(grant_id), 32'(b));
            end
        end
        #1;
        chk("t2_full_ready", 32'(req_ready), 0);
        chk("t2_full_level", 32'(level), 16);
        tick();
        chk("t2_full_winc", 32'(fifo_winc), 0);
        chk("t2_full_level2", 32'(level), 16);

        // 3: one pop at full gives exactly one beat, from req0 again
        fifo_pop = 1'b1;
        #1;
        chk("t3_pop_ready", 32'(req_ready), 0);
        tick();
        fifo_pop = 1'b0;
        chk("t3_level15", 32'(level), 15);
        chk("t3_winc0", 32'(fifo_winc), 0);
        #1;
        chk("t3_ready1", 32'(req_ready), 32'h1);
        tick();
        chk("t3_level16", 32'(level), 16);
        chk("t3_winc1", 32'(fifo_winc), 1);
        chk("t3_wdata", 32'(fifo_wdata), 32'h00);
        #1;
        chk("t3_ready_after", 32'(req_ready), 0);
        tick();
        chk("t3_winc_after", 32'(fifo_winc), 0);
        chk("t3_level_after", 32'(level), 16);

        // 4: req2 drops valid after 2 beats; req3 wins over req0 next
        do_reset();
        req_valid = 4'b0100;
        set_data(2, 8'hA0);
        #1;
        chk("t4_ready_a", 32'(req_ready), 32'h4);
        tick();
        chk("t4_grant2", 32'(grant_id), 2);
        set_data(2, 8'hA1);
        #1;
        chk("t4_ready_b", 32'(req_ready), 32'h4);
        tick();
        chk("t4_wdata_b", 32'(fifo_wdata), 32'hA1);
        req_valid = 4'b1001;
        set_data(0, 8'h0C);
        set_data(3, 8'h3C);
        #1;
        chk("t4_bubble", 32'(req_ready), 0);
        tick();
        chk("t4_bubble_winc", 32'(fifo_winc), 0);
        #1;
        chk("t4_ready3", 32'(req_ready), 32'h8);
        tick();
        chk("t4_grant3", 32'(grant_id), 3);
        chk("t4_wdata3", 32'(fifo_wdata), 32'h3C);
        chk("t4_level", 32'(level), 3);

        // 5: pop at empty is an error; accept+pop at level 5 keeps level
        do_reset();
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        chk("t5_pop_err", 32'(pop_err), 1);
        chk("t5_level0", 32'(level), 0);
        req_valid = 4'b0001;
        set_data(0, 8'h50);
        for (int k = 0; k < 5; k++) tick();
        chk("t5_level5", 32'(level), 5);
        fifo_pop = 1'b1;
        #1;
        chk("t5_ready_pop", 32'(req_ready), 32'h1);
        tick();
        fifo_pop  = 1'b0;
        req_valid = '0;
        chk("t5_level_same", 32'(level), 5);
        chk("t5_pop_err_sticky", 32'(pop_err), 1);

        // 6: asynchronous reset mid-burst, then restart from req0
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'h66);
        tick();
        tick();
        chk("t6_pre_winc", 32'(fifo_winc), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_winc", 32'(fifo_winc), 0);
        chk("t6_wdata", 32'(fifo_wdata), 0);
        chk("t6_level", 32'(level), 0);
        chk("t6_grant", 32'(grant_id), 0);
        chk("t6_ready", 32'(req_ready), 0);
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0011;
        set_data(0, 8'h70);
        set_data(1, 8'h71);
        #1;
        chk("t6_restart_ready", 32'(req_ready), 32'h1);
        tick();
        chk("t6_restart_wdata", 32'(fifo_wdata), 32'h70);
        chk("t6_restart_level", 32'(level), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
